// File: rtl/joypad_pkg.sv
// Shared definitions for the controller-port responder: button bit positions,
// the open-bus read pattern and the turbo masking helper.
package joypad_pkg;

  typedef logic [7:0] pad_t;

  localparam int JOY_A   = 0;
  localparam int JOY_B   = 1;
  localparam int JOY_SEL = 2;
  localparam int JOY_STA = 3;
  localparam int JOY_UP  = 4;
  localparam int JOY_DN  = 5;
  localparam int JOY_LT  = 6;
  localparam int JOY_RT  = 7;

  localparam pad_t OPEN_BUS = 8'h40;

  // A and B are gated by the turbo phase only when their turbo enable is set.
  function automatic pad_t turbo_mask(input pad_t joy, input logic [1:0] turbo,
                                      input logic phase);
    pad_t eff;
    eff         = joy;
    eff[JOY_A]  = joy[JOY_A] & (~turbo[0] | phase);
    eff[JOY_B]  = joy[JOY_B] & (~turbo[1] | phase);
    return eff;
  endfunction

endpackage

// File: rtl/joypad_port.sv
// One controller port: two-flop synchroniser for the pad byte, turbo mask and
// the strobe-reloaded serial shift register.
module joypad_port
  import joypad_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] joy_i,
  input  logic [1:0] turbo_i,
  input  logic       strobe_i,
  input  logic       phase_i,
  input  logic       shift_i,
  output logic       sr0_o
);

  pad_t meta_q;
  pad_t sync_q;
  pad_t sr_q;
  pad_t sr_d;
  pad_t eff_s;

  // Turbo-masked pad state and next shift-register value; reload beats shift.
  always_comb begin
    eff_s = turbo_mask(sync_q, turbo_i, phase_i);
    sr_d  = sr_q;
    if (strobe_i) begin
      sr_d = eff_s;
    end else if (shift_i) begin
      sr_d = {1'b1, sr_q[7:1]};
    end else begin
      sr_d = sr_q;
    end
  end

  // Synchroniser and shift-register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 8'h00;
      sync_q <= 8'h00;
      sr_q   <= 8'hFF;
    end else begin
      meta_q <= joy_i;
      sync_q <= meta_q;
      sr_q   <= sr_d;
    end
  end

  assign sr0_o = sr_q[0];

endmodule

// File: rtl/joypad.sv
// $4016/$4017 strobe-and-shift responder for two pads with a shared turbo
// phase generator; read data is registered and carries the open-bus pattern.
module joypad
  import joypad_pkg::*;
#(
  parameter int unsigned TURBO_HALF = 1666667
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       address,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  input  logic [7:0] joy1,
  input  logic [7:0] joy2,
  input  logic [1:0] turbo1,
  input  logic [1:0] turbo2
);

  localparam int unsigned CNT_W = (TURBO_HALF > 1) ? $clog2(TURBO_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TURBO_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             strobe_q, strobe_d;
  pad_t             data_q, data_d;
  logic             sr0_1_s, sr0_2_s;
  logic             shift1_s, shift2_s;
  logic             sel_bit_s;
  logic             unused_data_s;

  assign unused_data_s = ^data_i[7:1];

  // Turbo counter, strobe latch, read mux and per-port shift requests.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = {CNT_W{1'b0}};
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = phase_q;
    end

    // $4017 writes belong to the APU frame counter.
    if (wr && (address == 1'b0)) begin
      strobe_d = data_i[0];
    end else begin
      strobe_d = strobe_q;
    end

    sel_bit_s = address ? sr0_2_s : sr0_1_s;
    if (rd) begin
      data_d = {3'b010, 4'b0000, sel_bit_s};
    end else begin
      data_d = data_q;
    end

    shift1_s = rd & ~strobe_q & (address == 1'b0);
    shift2_s = rd & ~strobe_q & (address == 1'b1);
  end

  // Bus-side state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= {CNT_W{1'b0}};
      phase_q  <= 1'b0;
      strobe_q <= 1'b0;
      data_q   <= OPEN_BUS;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
    end
  end

  assign data_o = data_q;

  joypad_port u_port1 (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .joy_i    (joy1),
    .turbo_i  (turbo1),
    .strobe_i (strobe_q),
    .phase_i  (phase_q),
    .shift_i  (shift1_s),
    .sr0_o    (sr0_1_s)
  );

  joypad_port u_port2 (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .joy_i    (joy2),
    .turbo_i  (turbo2),
    .strobe_i (strobe_q),
    .phase_i  (phase_q),
    .shift_i  (shift2_s),
    .sr0_o    (sr0_2_s)
  );

endmodule

// File: tb/tb_joypad.sv
// Self-checking bench for joypad: expected read bytes are queued when a read
// is driven and compared when the registered data appears.
module tb_joypad;

  localparam int HALF = 4;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       address = 1'b0;
  logic       wr      = 1'b0;
  logic       rd      = 1'b0;
  logic [7:0] data_i  = 8'h00;
  logic [7:0] data_o;
  logic [7:0] joy1    = 8'h00;
  logic [7:0] joy2    = 8'h00;
  logic [1:0] turbo1  = 2'b00;
  logic [1:0] turbo2  = 2'b00;

  int         checks = 0;
  int         errors = 0;
  int         ecount;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  joypad #(.TURBO_HALF(HALF)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .address (address),
    .wr      (wr),
    .rd      (rd),
    .data_i  (data_i),
    .data_o  (data_o),
    .joy1    (joy1),
    .joy2    (joy2),
    .turbo1  (turbo1),
    .turbo2  (turbo2)
  );

  // Clock edges since the last reset release; gives the turbo phase reference.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) ecount <= 0;
    else          ecount <= ecount + 1;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got %h expected <empty scoreboard>", tag, data_o);
    end else begin
      check_eq(tag, data_o, exp_q.pop_front());
    end
  endtask

  task automatic wr_strobe(input logic a, input logic d);
    address = a;
    wr      = 1'b1;
    data_i  = {7'b0000000, d};
    tick();
    wr      = 1'b0;
  endtask

  task automatic rd_pad(input string tag, input logic a, input logic b);
    address = a;
    rd      = 1'b1;
    exp_q.push_back({7'b0100000, b});
    tick();
    rd      = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    logic [7:0] m;
    int         k;

    tick();
    tick();
    check_eq("reset_data", data_o, 8'h40);
    reset_n = 1'b1;

    // No strobe ever written: all-ones shift register.
    for (int i = 0; i < 9; i++) rd_pad("idle_read", 1'b0, 1'b1);

    // Full serial readout of pad 1.
    joy1 = 8'b1001_0101;
    joy2 = 8'h02;
    repeat (3) tick();
    wr_strobe(1'b0, 1'b1);
    wr_strobe(1'b0, 1'b0);
    m = joy1;
    for (int i = 0; i < 9; i++) begin
      rd_pad("serial", 1'b0, m[0]);
      m = {1'b1, m[7:1]};
    end

    // Strobe held: A tracked with 3-cycle latency, no shifting.
    wr_strobe(1'b0, 1'b1);
    wr_strobe(1'b1, 1'b0);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      joy1[0] = ~joy1[0];
      tick();
      tick();
      rd_pad("strobe_old", 1'b0, ~joy1[0]);
      rd_pad("strobe_new", 1'b0, joy1[0]);
      rd_pad("strobe_hold", 1'b0, joy1[0]);
    end
    rd_pad("strobe_pad2", 1'b1, joy2[0]);

    // Interleaved reads: each port shifts on its own address only.
    wr_strobe(1'b0, 1'b0);
    rd_pad("inter_p2_b0", 1'b1, 1'b0);
    rd_pad("inter_p1_b0", 1'b0, joy1[0]);
    rd_pad("inter_p2_b1", 1'b1, 1'b1);
    rd_pad("inter_p2_b2", 1'b1, 1'b0);
    rd_pad("inter_p1_b1", 1'b0, joy1[1]);

    // Turbo on A: back-to-back reads while strobed follow the phase.
    joy1   = 8'h01;
    turbo1 = 2'b01;
    wr_strobe(1'b0, 1'b1);
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      k = ecount + 1;
      rd_pad("turbo_on", 1'b0, 1'(((k - 2) / HALF) % 2));
    end
    turbo1 = 2'b00;
    tick();
    tick();
    for (int i = 0; i < 8; i++) rd_pad("turbo_off", 1'b0, 1'b1);

    // Read coinciding with the clearing write sees the strobed A, no shift.
    joy1 = 8'h01;
    repeat (3) tick();
    address = 1'b0;
    rd      = 1'b1;
    wr      = 1'b1;
    data_i  = 8'h00;
    exp_q.push_back(8'h41);
    tick();
    rd = 1'b0;
    wr = 1'b0;
    pop_check("rdwr_same");
    rd_pad("after_clr_a", 1'b0, 1'b1);
    rd_pad("after_clr_b", 1'b0, 1'b0);
    rd_pad("after_clr_sel", 1'b0, 1'b0);

    // Asynchronous reset mid-sequence.
    reset_n = 1'b0;
    #2;
    check_eq("mid_reset", data_o, 8'h40);
    tick();
    reset_n = 1'b1;
    rd_pad("post_reset_p1", 1'b0, 1'b1);
    rd_pad("post_reset_p2", 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
